// File: rtl/led_pulse_stretcher_pkg.sv
// led_pulse_stretcher_pkg
//   Shared definitions for the LED pulse stretcher.
//   - State encodings are exported as plain localparams so that debug-bus
//     decoders and benches can compare o_debug[7:6] against the same values
//     the RTL uses.
//   - Counter and queue widths.
//   - A helper that packs the debug word in one place.
package led_pulse_stretcher_pkg;

  localparam int CNT_W  = 16;  // blink phase counter width (max 65535 cycles)
  localparam int PEND_W = 3;   // pending-event queue width (max 7 events)

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ON   = 2'd1;
  localparam logic [1:0] STATE_OFF  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_ON   = STATE_ON,
    ST_OFF  = STATE_OFF
  } state_e;

  // Debug word layout: {state[1:0], led, overflow, pending[2:0], pulse}
  function automatic logic [7:0] pack_debug(
    input logic [1:0]        state,
    input logic              led,
    input logic              overflow,
    input logic [PEND_W-1:0] pending,
    input logic              pulse
  );
    return {state, led, overflow, pending, pulse};
  endfunction

endpackage

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
//   Turns single-cycle event strobes into human-visible LED blinks. Every
//   accepted event yields one blink of ON_CYCLES high followed by a mandatory
//   OFF_CYCLES low gap. Events that arrive while a blink is in progress are
//   queued in a saturating counter; an event that finds the queue full is
//   dropped and latches the sticky overflow flag.
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_pulse     event strobe; each high cycle is one event
//   i_clear     synchronous clear: drop queue, abort blink, clear overflow
//   o_led       registered LED drive, active high
//   o_busy      high while a blink is active or events are queued
//   o_pending   queued-event count
//   o_overflow  sticky lost-event flag
//   o_debug     {state[1:0], o_led, o_overflow, o_pending[2:0], i_pulse}
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES   = 5,
  parameter int OFF_CYCLES  = 5,
  parameter int MAX_PENDING = 7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pulse,
  input  logic              i_clear,
  output logic              o_led,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow,
  output logic [7:0]        o_debug
);

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PEND_W-1:0]   r_pending;
  logic                r_led;
  logic                r_overflow;

  state_e              w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [PEND_W-1:0]   w_pending_next;
  logic                w_led_next;
  logic                w_overflow_next;
  logic                w_start;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_led      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pending  <= w_pending_next;
      r_led      <= w_led_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_pending_next  = r_pending;
    w_overflow_next = r_overflow;
    w_start         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (r_pending != '0) begin
          w_start      = 1'b1;
          w_state_next = ST_ON;
        end
      end
      ST_ON: begin
        if (r_cnt == ON_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_OFF;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (r_cnt == OFF_LAST) begin
          w_cnt_next = '0;
          // Chain straight into the next queued blink with no idle cycle.
          if (r_pending != '0) begin
            w_start      = 1'b1;
            w_state_next = ST_ON;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        // Unused encoding: fall back to IDLE with the LED off.
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    // Arrival and consumption on the same edge cancel out, so a full queue
    // with a blink starting does not lose the new event.
    if (i_pulse && !w_start) begin
      if (r_pending == PEND_MAX) begin
        w_overflow_next = 1'b1;
      end else begin
        w_pending_next = r_pending + 1'b1;
      end
    end else if (!i_pulse && w_start) begin
      w_pending_next = r_pending - 1'b1;
    end

    if (i_clear) begin
      w_state_next    = ST_IDLE;
      w_cnt_next      = '0;
      w_pending_next  = '0;
      w_overflow_next = 1'b0;
    end

    // LED is registered from the next state so it is high exactly while in ON.
    w_led_next = (w_state_next == ST_ON);
  end

  assign o_led      = r_led;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != ST_IDLE) || (r_pending != '0);
  assign o_debug    = pack_debug(r_state, r_led, r_overflow, r_pending, i_pulse);

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher
//   Directed bench for led_pulse_stretcher with ON=5, OFF=5, MAX_PENDING=7.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that same
//   point, so "after edge k" below means the values registered by edge k.
module tb_led_pulse_stretcher;
  import led_pulse_stretcher_pkg::*;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_pulse;
  logic       i_clear;
  logic       o_led;
  logic       o_busy;
  logic [2:0] o_pending;
  logic       o_overflow;
  logic [7:0] o_debug;

  int n_tests = 0;
  int n_fail  = 0;

  led_pulse_stretcher #(
    .ON_CYCLES  (5),
    .OFF_CYCLES (5),
    .MAX_PENDING(7)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_pulse   (i_pulse),
    .i_clear   (i_clear),
    .o_led     (o_led),
    .o_busy    (o_busy),
    .o_pending (o_pending),
    .o_overflow(o_overflow),
    .o_debug   (o_debug)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rises;
  int max_pend;
  logic prev_led;

  initial begin
    i_reset = 1'b1;
    i_pulse = 1'b0;
    i_clear = 1'b0;
    #1;
    check("reset_led", 32'(o_led), 32'd0);
    check("reset_pending", 32'(o_pending), 32'd0);
    check("reset_overflow", 32'(o_overflow), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_debug", 32'(o_debug), 32'h00);
    step(); step(); step();
    i_reset = 1'b0;
    step();

    // --- single pulse: blink after edges 1..5, idle after edge 11 ---
    for (int k = 0; k <= 12; k++) begin
      i_pulse = (k == 0);
      step();
      check($sformatf("single_led_k%0d", k), 32'(o_led), 32'(k >= 1 && k <= 5));
      check($sformatf("single_busy_k%0d", k), 32'(o_busy), 32'(k <= 10));
      if (k == 0) check("single_pending_k0", 32'(o_pending), 32'd1);
      // state ON, led 1, overflow 0, pending 0, pulse 0
      if (k == 1) check("single_debug_k1", 32'(o_debug), 32'h60);
      if (k == 6) check("single_state_off", 32'(o_debug[7:6]), 32'(STATE_OFF));
    end

    // --- three pulses at k=0,2,4: blinks rise after k=1, 11, 21 ---
    max_pend = 0;
    for (int k = 0; k <= 34; k++) begin
      i_pulse = (k == 0 || k == 2 || k == 4);
      step();
      if (int'(o_pending) > max_pend) max_pend = int'(o_pending);
      check($sformatf("three_led_k%0d", k), 32'(o_led),
            32'((k >= 1 && k <= 5) || (k >= 11 && k <= 15) || (k >= 21 && k <= 25)));
    end
    check("three_max_pending", 32'(max_pend), 32'd2);
    check("three_busy_end", 32'(o_busy), 32'd0);

    // --- pulse held 10 cycles: queue saturates, 8 blinks total ---
    rises = 0;
    max_pend = 0;
    prev_led = 1'b0;
    for (int k = 0; k <= 90; k++) begin
      i_pulse = (k < 10);
      step();
      if (o_led && !prev_led) rises++;
      prev_led = o_led;
      if (int'(o_pending) > max_pend) max_pend = int'(o_pending);
      if (k == 7) check("sat_pending_k7", 32'(o_pending), 32'd7);
      if (k == 7) check("sat_overflow_k7", 32'(o_overflow), 32'd0);
      if (k == 8) check("sat_overflow_k8", 32'(o_overflow), 32'd1);
    end
    check("sat_max_pending", 32'(max_pend), 32'd7);
    check("sat_blinks", 32'(rises), 32'd8);
    check("sat_overflow_sticky", 32'(o_overflow), 32'd1);
    check("sat_busy_end", 32'(o_busy), 32'd0);

    // --- pulse on the edge a queued blink starts, pending=3 ---
    for (int k = 0; k <= 11; k++) begin
      i_pulse = (k <= 3) || (k == 11);
      step();
      if (k == 10) check("same_edge_pending_before", 32'(o_pending), 32'd3);
      if (k == 10) check("same_edge_led_before", 32'(o_led), 32'd0);
    end
    check("same_edge_pending_after", 32'(o_pending), 32'd3);
    check("same_edge_led_after", 32'(o_led), 32'd1);

    // --- clear mid-ON with pending=4 and overflow still set ---
    i_pulse = 1'b1;
    step();
    check("clear_pending_pre", 32'(o_pending), 32'd4);
    check("clear_overflow_pre", 32'(o_overflow), 32'd1);
    check("clear_led_pre", 32'(o_led), 32'd1);
    i_clear = 1'b1;
    i_pulse = 1'b1;
    step();
    i_clear = 1'b0;
    i_pulse = 1'b0;
    check("clear_led", 32'(o_led), 32'd0);
    check("clear_pending", 32'(o_pending), 32'd0);
    check("clear_overflow", 32'(o_overflow), 32'd0);
    check("clear_state", 32'(o_debug[7:6]), 32'(STATE_IDLE));
    check("clear_busy", 32'(o_busy), 32'd0);
    step();
    check("clear_pulse_dropped_led", 32'(o_led), 32'd0);
    check("clear_pulse_dropped_pend", 32'(o_pending), 32'd0);

    // --- async reset mid-cycle while ON ---
    i_pulse = 1'b1;
    step();
    i_pulse = 1'b0;
    step();
    check("areset_led_pre", 32'(o_led), 32'd1);
    #3;
    i_reset = 1'b1;
    #1;
    check("areset_led", 32'(o_led), 32'd0);
    check("areset_debug", 32'(o_debug), 32'h00);
    check("areset_busy", 32'(o_busy), 32'd0);
    #1;
    i_reset = 1'b0;
    i_pulse = 1'b1;
    step();
    i_pulse = 1'b0;
    check("post_reset_pending", 32'(o_pending), 32'd1);
    check("post_reset_led_t", 32'(o_led), 32'd0);
    step();
    check("post_reset_led_t1", 32'(o_led), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
